// File: rtl/vmem_write_scheduler_if.sv
// vmem_write_scheduler_if: store request, clear control and text-memory write port bundle
interface vmem_write_scheduler_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 4
);
    logic                   req_valid;
    logic [ADDR_WIDTH-3:0]  req_addr;
    logic [3:0]             req_byte_en;
    logic [31:0]            req_data;
    logic                   req_stall;
    logic                   clear_start;
    logic                   clear_busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [7:0]             mem_data;
    logic                   mem_wen;
    modport master (
        output req_valid, req_addr, req_byte_en, req_data, clear_start,
        input  req_stall, clear_busy, fifo_count, mem_addr, mem_data, mem_wen
    );
    modport slave (
        input  req_valid, req_addr, req_byte_en, req_data, clear_start,
        output req_stall, clear_busy, fifo_count, mem_addr, mem_data, mem_wen
    );
endinterface

// File: rtl/vmem_write_scheduler.sv
// vmem_write_scheduler: buffers byte stores to text memory as setup/strobe writes, with an ordered clear engine
module vmem_write_scheduler #(
    parameter int         ADDR_WIDTH = 15,
    parameter int         DEPTH      = 4,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter int         CLEAR_LAST = 2**ADDR_WIDTH-1
) (
    input logic                   clk,
    input logic                   rst,
    vmem_write_scheduler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [CW-1:0]         LP_FULL     = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_CLR_LAST = ADDR_WIDTH'(CLEAR_LAST);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_CLR_SETUP, ST_CLR_STROBE} state_t;

    state_t                r_state, w_next;
    logic [WW-1:0]         r_fifo_addr [DEPTH];
    logic [3:0]            r_fifo_be   [DEPTH];
    logic [31:0]           r_fifo_data [DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_clr_busy;
    logic [WW-1:0]         r_waddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_rem;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_data;
    logic                  w_push, w_pop, w_load, w_adv, w_clr_begin, w_clr_inc, w_clr_done, w_have;
    logic [3:0]            w_head_lanes, w_rem_next, w_src_lanes;
    logic [1:0]            w_src_lane;
    logic [31:0]           w_src_data;
    logic [WW-1:0]         w_src_addr;

    function automatic logic [1:0] f_first(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // Lane-ordered enables: bit k set means lane k (byte_en bit 3-k) still has to be written
    assign w_head_lanes = {r_fifo_be[r_rd_ptr][0], r_fifo_be[r_rd_ptr][1],
                           r_fifo_be[r_rd_ptr][2], r_fifo_be[r_rd_ptr][3]};
    assign w_rem_next   = r_rem & ~(4'b0001 << r_lane);
    assign w_have       = r_count != '0;
    assign w_src_lanes  = w_load ? w_head_lanes : w_rem_next;
    assign w_src_lane   = f_first(w_src_lanes);
    assign w_src_data   = w_load ? r_fifo_data[r_rd_ptr] : r_wdata;
    assign w_src_addr   = w_load ? r_fifo_addr[r_rd_ptr] : r_waddr;
    assign w_push       = bus.req_valid && !bus.req_stall;

    assign bus.req_stall  = bus.req_valid && (r_count == LP_FULL || r_clr_busy);
    assign bus.clear_busy = r_clr_busy;
    assign bus.fifo_count = r_count;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.mem_wen    = r_state == ST_STROBE || r_state == ST_CLR_STROBE;

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_clr_begin = 1'b0;
        w_clr_inc   = 1'b0;
        w_clr_done  = 1'b0;
        case (r_state)
            ST_IDLE, ST_STROBE: begin
                if (r_state == ST_STROBE && w_rem_next != '0) begin
                    w_next = ST_SETUP;
                    w_adv  = 1'b1;
                end else if (w_have) begin
                    w_pop  = 1'b1;
                    w_load = w_head_lanes != '0;
                    w_next = w_load ? ST_SETUP : ST_IDLE;
                end else if (r_clr_busy) begin
                    w_next      = ST_CLR_SETUP;
                    w_clr_begin = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETUP:     w_next = ST_STROBE;
            ST_CLR_SETUP: w_next = ST_CLR_STROBE;
            ST_CLR_STROBE: begin
                w_clr_done = r_mem_addr == LP_CLR_LAST;
                w_clr_inc  = !w_clr_done;
                w_next     = w_clr_done ? ST_IDLE : ST_CLR_SETUP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.req_addr;
            r_fifo_be[r_wr_ptr]   <= bus.req_byte_en;
            r_fifo_data[r_wr_ptr] <= bus.req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_clr_busy <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_rem      <= '0;
            r_lane     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state  <= w_next;
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            if (bus.clear_start && !r_clr_busy)
                r_clr_busy <= 1'b1;
            else if (w_clr_done)
                r_clr_busy <= 1'b0;
            if (w_load || w_adv) begin
                r_waddr    <= w_src_addr;
                r_wdata    <= w_src_data;
                r_rem      <= w_src_lanes;
                r_lane     <= w_src_lane;
                r_mem_addr <= {w_src_addr, w_src_lane};
                r_mem_data <= w_src_data[8*w_src_lane +: 8];
            end else if (w_clr_begin || w_clr_inc) begin
                r_mem_addr <= w_clr_begin ? '0 : r_mem_addr + ADDR_WIDTH'(1);
                r_mem_data <= CLEAR_CHAR;
            end
        end
    end
endmodule
